// File: rtl/case_5_mul_pipe_sat.sv
// Pipelined, clock-enabled integer multiplier with per-operand signedness,
// a valid chain, optional output saturation and an overflow flag.
//
// Handshake: there is no backpressure. din_vld qualifies din0/din1 on a
// ce-high edge. dout_vld qualifies dout/dout_ovf. All three hold while ce=0.
//
// Pipeline shape:
//   NUM_STAGE == 1 : result computed from din0/din1, then registered.
//   NUM_STAGE >= 2 : stage 1 registers the operands, stage 2 the result,
//                    and NUM_STAGE-2 further delay stages follow.
module case_5_mul_pipe_sat #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 6,
    parameter int SIGNED0    = 1,
    parameter int SIGNED1    = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  dout_ovf
);

    // Exact product width: both operands extended to P bits cover every
    // signed/unsigned combination without loss.
    localparam int P  = din0_WIDTH + din1_WIDTH + 1;
    // Comparison width, wide enough for any P and any dout range bound.
    localparam int XW = 72;
    // Number of result registers after the multiply.
    localparam int D  = (NUM_STAGE == 1) ? 1 : NUM_STAGE - 1;
    localparam bit SIGNED_RES = (SIGNED0 != 0) || (SIGNED1 != 0);

    localparam logic signed [XW-1:0] ONE   = 1;
    localparam logic signed [XW-1:0] MAX_V = SIGNED_RES ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                                        : (ONE <<< dout_WIDTH) - ONE;
    localparam logic signed [XW-1:0] MIN_V = SIGNED_RES ? -(ONE <<< (dout_WIDTH - 1))
                                                        : {XW{1'b0}};

    // Elaboration-time parameter legality checks.
    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_num_stage
        $error("case_5_mul_pipe_sat: NUM_STAGE must be 1..8");
    end
    if (din0_WIDTH < 2 || din0_WIDTH > 32) begin : g_bad_din0_width
        $error("case_5_mul_pipe_sat: din0_WIDTH must be 2..32");
    end
    if (din1_WIDTH < 2 || din1_WIDTH > 32) begin : g_bad_din1_width
        $error("case_5_mul_pipe_sat: din1_WIDTH must be 2..32");
    end
    if (dout_WIDTH < 2 || dout_WIDTH > 64) begin : g_bad_dout_width
        $error("case_5_mul_pipe_sat: dout_WIDTH must be 2..64");
    end
    if ((SIGNED0 != 0 && SIGNED0 != 1) || (SIGNED1 != 0 && SIGNED1 != 1) ||
        (SATURATE != 0 && SATURATE != 1)) begin : g_bad_flags
        $error("case_5_mul_pipe_sat: SIGNED0/SIGNED1/SATURATE must be 0 or 1");
    end
    if (ID < 0) begin : g_bad_id
        $error("case_5_mul_pipe_sat: ID must be non-negative");
    end

    // Operands feeding the multiplier.
    logic [din0_WIDTH-1:0] op0;
    logic [din1_WIDTH-1:0] op1;
    logic                  op_vld;

    if (NUM_STAGE == 1) begin : g_direct
        assign op0    = din0;
        assign op1    = din1;
        assign op_vld = din_vld;
    end else begin : g_opreg
        logic [din0_WIDTH-1:0] din0_q, din0_d;
        logic [din1_WIDTH-1:0] din1_q, din1_d;
        logic                  din_vld_q, din_vld_d;

        // Operand stage next-state: capture inputs on ce, otherwise hold.
        always_comb begin
            din0_d    = din0_q;
            din1_d    = din1_q;
            din_vld_d = din_vld_q;
            if (ce) begin
                din0_d    = din0;
                din1_d    = din1;
                din_vld_d = din_vld;
            end
        end

        // Operand stage registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                din0_q    <= '0;
                din1_q    <= '0;
                din_vld_q <= 1'b0;
            end else begin
                din0_q    <= din0_d;
                din1_q    <= din1_d;
                din_vld_q <= din_vld_d;
            end
        end

        assign op0    = din0_q;
        assign op1    = din1_q;
        assign op_vld = din_vld_q;
    end

    logic signed [P-1:0]    a_ext;
    logic signed [P-1:0]    b_ext;
    logic signed [P-1:0]    prod;
    logic signed [XW-1:0]   prod_x;
    logic                   ovf_n;
    logic [dout_WIDTH-1:0]  res_n;

    // Exact multiply, range check and wrap/saturate selection.
    always_comb begin
        a_ext  = {{(P - din0_WIDTH){(SIGNED0 != 0) & op0[din0_WIDTH-1]}}, op0};
        b_ext  = {{(P - din1_WIDTH){(SIGNED1 != 0) & op1[din1_WIDTH-1]}}, op1};
        prod   = a_ext * b_ext;
        prod_x = {{(XW - P){prod[P-1]}}, prod};
        ovf_n  = (prod_x > MAX_V) || (prod_x < MIN_V);
        res_n  = prod_x[dout_WIDTH-1:0];
        if ((SATURATE != 0) && ovf_n) begin
            // An overflowing product is never zero, so sign picks the bound.
            res_n = prod_x[XW-1] ? MIN_V[dout_WIDTH-1:0] : MAX_V[dout_WIDTH-1:0];
        end
    end

    logic [dout_WIDTH-1:0] res_q [D];
    logic [dout_WIDTH-1:0] res_d [D];
    logic [D-1:0]          ovf_q, ovf_d;
    logic [D-1:0]          vld_q, vld_d;

    // Result delay line next-state: shift on ce, otherwise hold.
    always_comb begin
        res_d = res_q;
        ovf_d = ovf_q;
        vld_d = vld_q;
        if (ce) begin
            res_d[0] = res_n;
            ovf_d[0] = ovf_n;
            vld_d[0] = op_vld;
            for (int i = 1; i < D; i++) begin
                res_d[i] = res_q[i-1];
                ovf_d[i] = ovf_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Result delay line registers; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                res_q[i] <= '0;
            end
            ovf_q <= '0;
            vld_q <= '0;
        end else begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign dout     = res_q[D-1];
    assign dout_ovf = ovf_q[D-1];
    assign dout_vld = vld_q[D-1];

endmodule
